// File: rtl/fma_acc_sequencer.sv
// fma_acc_sequencer
//   Sequences a multi-channel dot-product job onto one dualFMA instance and
//   owns the per-channel accumulator bank. Input beats arrive k-major,
//   channel-minor, so consecutive issues target different channels. With at
//   least FMA_LAT channels, no issue ever waits on an FMA result that is
//   still in flight. Final sums drain on a valid/ready output stream.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, cfg_*          job start pulse and configuration (latched in IDLE)
//   busy, done, cfg_err   job status (done/cfg_err are one-cycle pulses)
//   in_valid/in_ready     input beat handshake; in_act (FP16), in_wt (weight)
//   fma_*                 operands to the FMA and its acc1/acc2 results
//   out_valid/out_ready   result handshake; out_ch, out_acc1, out_acc2
module fma_acc_sequencer #(
  parameter int MAX_CH  = 8,
  parameter int K_W     = 12,
  parameter int FMA_LAT = 2,
  localparam int NCH_W  = $clog2(MAX_CH + 1),
  localparam int CH_W   = $clog2(MAX_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_mode,
  input  logic [NCH_W-1:0] cfg_nch,
  input  logic [K_W-1:0]   cfg_klen,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_act,
  input  logic [7:0]       in_wt,
  output logic [15:0]      fma_act,
  output logic [7:0]       fma_in,
  output logic             fma_mode,
  output logic [15:0]      fma_acc1,
  output logic [15:0]      fma_acc2,
  input  logic [15:0]      fma_acc1_res,
  input  logic [15:0]      fma_acc2_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [15:0]      out_acc1,
  output logic [15:0]      out_acc2
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              mode_q;
  logic [NCH_W-1:0]  nch_q;
  logic [K_W-1:0]    klen_q;
  logic [K_W-1:0]    k_q;
  logic [CH_W-1:0]   ch_q;
  logic              done_q, cfg_err_q;

  // In-flight tracker: one slot per FMA pipeline stage; the tail slot lines
  // up with the cycle in which the FMA presents that issue's result.
  logic [FMA_LAT-1:0] trk_valid;
  logic [CH_W-1:0]    trk_ch [FMA_LAT];

  logic [15:0] bank_acc1 [MAX_CH];
  logic [15:0] bank_acc2 [MAX_CH];

  logic            cfg_ok, fire, ch_last, k_last, tail_valid, bypass;
  logic [CH_W-1:0] tail_ch;

  assign cfg_ok     = (cfg_nch >= NCH_W'(FMA_LAT)) && (cfg_nch <= NCH_W'(MAX_CH))
                      && (cfg_klen != '0);
  assign fire       = (state_q == RUN) && in_valid;
  assign ch_last    = (NCH_W'(ch_q) == nch_q - NCH_W'(1));
  assign k_last     = (k_q == klen_q - K_W'(1));
  assign tail_valid = trk_valid[FMA_LAT-1];
  assign tail_ch    = trk_ch[FMA_LAT-1];
  // A result landing this cycle for the channel being issued is newer than
  // the bank copy, so it is forwarded straight to the FMA.
  assign bypass     = tail_valid && (tail_ch == ch_q);

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == DRAIN);
  assign out_ch    = out_valid ? ch_q : '0;
  assign out_acc2  = out_valid ? bank_acc2[ch_q] : 16'h0000;
  assign out_acc1  = (out_valid && mode_q) ? bank_acc1[ch_q] : 16'h0000;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign fma_mode  = mode_q;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    fma_act  = 16'h0000;
    fma_in   = 8'h00;
    fma_acc1 = 16'h0000;
    fma_acc2 = 16'h0000;
    if (fire) begin
      fma_act = in_act;
      fma_in  = in_wt;
      if (k_q != '0) begin
        fma_acc1 = bypass ? fma_acc1_res : bank_acc1[ch_q];
        fma_acc2 = bypass ? fma_acc2_res : bank_acc2[ch_q];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start && cfg_ok) state_d = RUN;
      RUN:   if (fire && ch_last && k_last) state_d = FLUSH;
      FLUSH: if (trk_valid == '0) state_d = DRAIN;
      DRAIN: if (out_ready && ch_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      nch_q     <= '0;
      klen_q    <= '0;
      k_q       <= '0;
      ch_q      <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      trk_valid <= '0;
      for (int i = 0; i < FMA_LAT; i++) trk_ch[i] <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= (state_q == DRAIN) && out_ready && ch_last;
      cfg_err_q <= (state_q == IDLE) && start && !cfg_ok;

      trk_valid[0] <= fire;
      trk_ch[0]    <= ch_q;
      for (int i = 1; i < FMA_LAT; i++) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_ch[i]    <= trk_ch[i-1];
      end

      case (state_q)
        IDLE: if (start && cfg_ok) begin
          mode_q <= cfg_mode;
          nch_q  <= cfg_nch;
          klen_q <= cfg_klen;
          k_q    <= '0;
          ch_q   <= '0;
        end
        RUN: if (fire) begin
          if (ch_last) begin
            ch_q <= '0;
            k_q  <= k_q + K_W'(1);
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        FLUSH: ch_q <= '0;
        DRAIN: if (out_ready) ch_q <= ch_last ? '0 : ch_q + CH_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the accumulator bank is deliberately not reset; each job's k=0
  // pass writes every channel before any read of it.
  always_ff @(posedge clk) begin
    if (!reset && tail_valid) begin
      bank_acc1[tail_ch] <= fma_acc1_res;
      bank_acc2[tail_ch] <= fma_acc2_res;
    end
  end

endmodule

// File: tb/tb_fma_acc_sequencer.sv
module tb_fma_acc_sequencer;

  localparam int FMA_LAT = 2;

  logic        clk = 1'b0;
  logic        reset, start, cfg_mode;
  logic [3:0]  cfg_nch;
  logic [11:0] cfg_klen;
  logic        busy, done, cfg_err;
  logic        in_valid, in_ready;
  logic [15:0] in_act;
  logic [7:0]  in_wt;
  logic [15:0] fma_act, fma_acc1, fma_acc2, fma_acc1_res, fma_acc2_res;
  logic [7:0]  fma_in;
  logic        fma_mode;
  logic        out_valid, out_ready;
  logic [2:0]  out_ch;
  logic [15:0] out_acc1, out_acc2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] act_tab [64];
  logic [7:0]  wt_tab  [64];

  fma_acc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
    .cfg_nch(cfg_nch), .cfg_klen(cfg_klen), .busy(busy), .done(done),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wt(in_wt), .fma_act(fma_act), .fma_in(fma_in),
    .fma_mode(fma_mode), .fma_acc1(fma_acc1), .fma_acc2(fma_acc2),
    .fma_acc1_res(fma_acc1_res), .fma_acc2_res(fma_acc2_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_acc1(out_acc1), .out_acc2(out_acc2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- number helpers ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    real v;
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    if (e == 0) v = real'(m) * pow2(-24);
    else        v = (1.0 + real'(m) / 1024.0) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real v);
    real  a;
    int   e, m;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic real fp4_to_real(input logic [3:0] b);
    real v;
    if (b[2:1] == 2'b00) v = b[0] ? 0.5 : 0.0;
    else                 v = (b[0] ? 1.5 : 1.0) * pow2(int'(b[2:1]) - 1);
    return b[3] ? -v : v;
  endfunction

  function automatic real int8_to_real(input logic [7:0] w);
    int i = int'($signed(w));
    return real'(i);
  endfunction

  // ---------------- dualFMA stand-in ----------------
  // Lane 1 is unused in int8 mode; the model still scribbles on it so that a
  // missing output mask shows up.
  function automatic logic [31:0] fma_model(input logic mode, input logic [15:0] act,
                                            input logic [7:0] wt,
                                            input logic [15:0] a1, input logic [15:0] a2);
    real x = fp16_to_real(act);
    real n1, n2;
    if (!mode) begin
      n1 = fp16_to_real(a1) + x;
      n2 = fp16_to_real(a2) + x * int8_to_real(wt);
    end else begin
      n1 = fp16_to_real(a1) + x * fp4_to_real(wt[7:4]);
      n2 = fp16_to_real(a2) + x * fp4_to_real(wt[3:0]);
    end
    return {real_to_fp16(n1), real_to_fp16(n2)};
  endfunction

  logic [31:0] pipe [FMA_LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FMA_LAT; i++) pipe[i] <= 32'h0;
    end else begin
      pipe[0] <= fma_model(fma_mode, fma_act, fma_in, fma_acc1, fma_acc2);
      for (int i = 1; i < FMA_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fma_acc1_res = pipe[FMA_LAT-1][31:16];
  assign fma_acc2_res = pipe[FMA_LAT-1][15:0];

  // ---------------- generic job runner ----------------
  // gap_kind: 0 continuous valid, 1 toggling valid, 2 random valid.
  // bp_at: result index at which out_ready is held low for 5 cycles (-1: none).
  task automatic run_job(input string name, input bit mode, input int nch, input int klen,
                         input int gap_kind, input int bp_at);
    int          total = nch * klen;
    int          beat = 0, budget = 0, fire_cyc = 0, idx = 0, low = 0;
    bit          seen = 0, tog = 1;
    real         s1 [8];
    real         s2 [8];
    logic [15:0] e1 [8];
    logic [15:0] e2 [8];

    for (int c = 0; c < 8; c++) begin s1[c] = 0.0; s2[c] = 0.0; end
    for (int b = 0; b < total; b++) begin
      real x = fp16_to_real(act_tab[b]);
      if (mode) begin
        s1[b % nch] += x * fp4_to_real(wt_tab[b][7:4]);
        s2[b % nch] += x * fp4_to_real(wt_tab[b][3:0]);
      end else begin
        s2[b % nch] += x * int8_to_real(wt_tab[b]);
      end
    end
    for (int c = 0; c < 8; c++) begin
      e1[c] = mode ? real_to_fp16(s1[c]) : 16'h0000;
      e2[c] = real_to_fp16(s2[c]);
    end

    @(negedge clk);
    cfg_mode = mode; cfg_nch = 4'(nch); cfg_klen = 12'(klen); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start: busy=%b cfg_err=%b, want busy=1 cfg_err=0", name, busy, cfg_err);
    end

    while (beat < total && budget < 2000) begin
      case (gap_kind)
        0:       in_valid = 1'b1;
        1:       begin in_valid = tog; tog = !tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_act = act_tab[beat];
      in_wt  = wt_tab[beat];
      #1;
      n_cmp++;
      if (in_valid && in_ready) begin
        if (fma_act !== in_act || fma_in !== in_wt || fma_mode !== mode) begin
          n_bad++;
          $display("FAIL %s issue beat %0d: act=%h in=%h mode=%b, want %h %h %b",
                   name, beat, fma_act, fma_in, fma_mode, in_act, in_wt, mode);
        end
        if (beat < nch) begin
          n_cmp++;
          if (fma_acc1 !== 16'h0 || fma_acc2 !== 16'h0) begin
            n_bad++;
            $display("FAIL %s k0 acc beat %0d: acc1=%h acc2=%h, want 0000 0000",
                     name, beat, fma_acc1, fma_acc2);
          end
        end
        fire_cyc = cyc + 1;
        beat++;
      end else if (fma_act !== 16'h0 || fma_in !== 8'h0 || fma_acc1 !== 16'h0 ||
                   fma_acc2 !== 16'h0) begin
        n_bad++;
        $display("FAIL %s idle issue: act=%h in=%h acc1=%h acc2=%h, want all 0",
                 name, fma_act, fma_in, fma_acc1, fma_acc2);
      end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    if (beat < total) begin
      n_cmp++; n_bad++;
      $display("FAIL %s input timeout: accepted %0d beats, want %0d", name, beat, total);
    end
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s in_ready after last beat: got %b want 0", name, in_ready);
    end

    budget = 0;
    while (idx < nch && budget < 500) begin
      out_ready = 1'b1;
      #1;
      if (out_valid === 1'b1) begin
        if (idx == bp_at && low < 5) begin out_ready = 1'b0; low++; end
        if (!seen) begin
          seen = 1;
          n_cmp++;
          if (cyc - fire_cyc != FMA_LAT + 1) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, cyc - fire_cyc, FMA_LAT + 1);
          end
        end
        n_cmp++;
        if (out_ch !== 3'(idx) || out_acc1 !== e1[idx] || out_acc2 !== e2[idx]) begin
          n_bad++;
          $display("FAIL %s result %0d (ready=%b): ch=%0d acc1=%h acc2=%h, want ch=%0d acc1=%h acc2=%h",
                   name, idx, out_ready, out_ch, out_acc1, out_acc2, idx, e1[idx], e2[idx]);
        end
        if (out_ready) idx++;
      end
      @(negedge clk);
      budget++;
    end
    if (idx < nch) begin
      n_cmp++; n_bad++;
      $display("FAIL %s drain timeout: got %0d results want %0d", name, idx, nch);
    end
    #1;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done: done=%b busy=%b out_valid=%b, want 1 0 0", name, done, busy, out_valid);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done pulse width: done=%b want 0", name, done);
    end
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_nch = '0; cfg_klen = '0;
    in_valid = 1'b0; in_act = '0; in_wt = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, cfg_err, in_ready, out_valid} !== 5'b0 || out_ch !== 3'd0 ||
        out_acc1 !== 16'h0 || out_acc2 !== 16'h0 || fma_act !== 16'h0 || fma_in !== 8'h0 ||
        fma_mode !== 1'b0 || fma_acc1 !== 16'h0 || fma_acc2 !== 16'h0) begin
      n_bad++;
      $display("FAIL reset state: busy=%b done=%b err=%b rdy=%b ov=%b ch=%0d a1=%h a2=%h fma=%h/%h/%b/%h/%h, want all 0",
               busy, done, cfg_err, in_ready, out_valid, out_ch, out_acc1, out_acc2,
               fma_act, fma_in, fma_mode, fma_acc1, fma_acc2);
    end
  endtask

  task automatic fill(input logic [15:0] act, input logic [7:0] wt);
    for (int b = 0; b < 64; b++) begin act_tab[b] = act; wt_tab[b] = wt; end
  endtask

  task automatic test_int8_bypass();
    fill(16'h3C00, 8'h02);
    run_job("int8_bypass", 1'b0, 2, 3, 0, -1);
  endtask

  task automatic test_fp4();
    fill(16'h4000, 8'h22);
    run_job("fp4", 1'b1, 3, 2, 0, -1);
  endtask

  task automatic test_gaps();
    fill(16'h3C00, 8'hFF);
    for (int b = 0; b < 64; b += 4) wt_tab[b] = 8'h01;
    run_job("gaps", 1'b0, 4, 2, 1, -1);
  endtask

  task automatic randomize_tables(input bit mode);
    logic [15:0] acts [4];
    acts[0] = 16'h3C00; acts[1] = 16'h4000; acts[2] = 16'h3800; acts[3] = 16'hBC00;
    for (int b = 0; b < 64; b++) begin
      act_tab[b] = acts[$urandom_range(0, 3)];
      if (mode) wt_tab[b] = 8'($urandom_range(0, 255));
      else      wt_tab[b] = 8'($urandom_range(0, 16) - 8);
    end
  endtask

  task automatic test_backpressure();
    randomize_tables(1'b1);
    run_job("backpressure", 1'b1, 4, 2, 0, 2);
  endtask

  task automatic test_cfg_err(input string name, input int nch, input int klen);
    @(negedge clk);
    cfg_mode = 1'b0; cfg_nch = 4'(nch); cfg_klen = 12'(klen); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: cfg_err=%b busy=%b in_ready=%b, want 1 0 0", name, cfg_err, busy, in_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after: cfg_err=%b busy=%b in_ready=%b, want 0 0 0", name, cfg_err, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    fill(16'h3C00, 8'h05);
    @(negedge clk);
    cfg_mode = 1'b0; cfg_nch = 4'd2; cfg_klen = 12'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; in_act = act_tab[b]; in_wt = wt_tab[b];
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b in_ready=%b out_valid=%b done=%b, want 0 0 0 0",
               busy, in_ready, out_valid, done);
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid idle: done=%b busy=%b, want 0 0", done, busy);
      end
    end
    fill(16'h3C00, 8'h03);
    run_job("after_reset", 1'b0, 2, 1, 0, -1);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++) begin
      bit m   = 1'($urandom_range(0, 1));
      int nch = $urandom_range(2, 8);
      int kl  = $urandom_range(1, 6);
      randomize_tables(m);
      run_job($sformatf("random%0d", j), m, nch, kl, $urandom_range(0, 2),
              $urandom_range(0, nch - 1));
    end
  endtask

  initial begin
    test_reset();
    test_int8_bypass();
    test_fp4();
    test_gaps();
    test_backpressure();
    test_cfg_err("cfg_err_nch1", 1, 4);
    test_cfg_err("cfg_err_klen0", 2, 0);
    test_reset_mid();
    test_random_jobs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fma_acc_sequencer.md
Name: fma_acc_sequencer

Overview:
- Drives one dualFMA instance for a multi-channel dot-product job and owns its accumulator state.
- Accepts a valid/ready stream of (FP16 activation, 8-bit weight) beats ordered k-major, channel-minor.
- Interleaves output channels so that back-to-back issues never depend on an in-flight FMA result.
- Feeds acc1/acc2 back from an internal bank, then drains the final sums on a valid/ready output stream.

Parameters:
MAX_CH, 8, accumulator bank depth (max output channels per job)
K_W, 12, width of cfg_klen
FMA_LAT, 2, cycles from FMA input sample edge to valid acc1_out/acc2_out

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  job start pulse, sampled in IDLE only
cfg_mode  in  1  0: int8, 1: 2fp4; latched at start
cfg_nch  in  $clog2(MAX_CH+1)  channel count; latched at start
cfg_klen  in  K_W  reduction length; latched at start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last output handshake
cfg_err  out  1  one-cycle pulse on a rejected start
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_act  in  16  FP16 activation
in_wt  in  8  int8 or packed 2xFP4 weight
fma_act  out  16  to FMA act
fma_in  out  8  to FMA in
fma_mode  out  1  to FMA mode
fma_acc1  out  16  to FMA acc1
fma_acc2  out  16  to FMA acc2
fma_acc1_res  in  16  from FMA acc1_out
fma_acc2_res  in  16  from FMA acc2_out
out_valid  out  1  result valid
out_ready  in  1  result accepted
out_ch  out  $clog2(MAX_CH)  channel index of result
out_acc1  out  16  lane-1 sum (0x0000 in mode 0)
out_acc2  out  16  lane-2 sum

Behaviour:
- States: IDLE, RUN, FLUSH, DRAIN.
- Reset: state IDLE; busy, done, cfg_err, in_ready and out_valid are 0; out_ch, out_acc1, out_acc2 and all fma_* outputs are 0; in-flight tracker cleared.
- IDLE, start=1, valid config: latch the config, k=0, ch=0, go to RUN, busy=1 from the next cycle.
- Config is valid when FMA_LAT <= cfg_nch <= MAX_CH and cfg_klen != 0.
- IDLE, start=1, invalid config: cfg_err pulses 1 cycle, stay in IDLE.
- start outside IDLE is ignored.
- RUN:
  - in_ready=1 until nch*klen beats have been accepted.
  - Fire = in_valid & in_ready. On fire, fma_act=in_act, fma_in=in_wt, fma_mode=latched mode, all combinational in the same cycle.
  - On fire, fma_acc1/fma_acc2 = 0x0000 when k==0; otherwise they are bank[ch].
  - On non-fire cycles, fma_act, fma_in, fma_acc1 and fma_acc2 are 0 and fma_mode holds the latched mode.
  - On fire, push {valid, ch} into a FMA_LAT-deep tracker. Advance ch; when ch wraps at nch-1, reset it to 0 and increment k.
- Writeback: when the tracker tail is valid, bank[tail.ch] <= {fma_acc1_res, fma_acc2_res}.
- Bypass: if a writeback and a fire target the same ch in the same cycle, fma_acc1/fma_acc2 take the writeback data, not bank contents. This occurs whenever nch==FMA_LAT under continuous valid.
- Gaps in in_valid only lengthen spacing and need no special handling.
- FLUSH: entered after the final beat fires, with in_ready=0. Wait until the tracker is empty, then go to DRAIN with ch=0.
- DRAIN:
  - out_valid=1 with out_ch=ch, out_acc2=bank[ch].acc2, and out_acc1=bank[ch].acc1 in mode 1 or 0x0000 in mode 0.
  - Outputs hold stable while out_ready=0.
  - On handshake, ch increments. After the handshake on ch=nch-1: out_valid=0, done=1 for one cycle, busy=0, go to IDLE.
- Latency: the final result is first visible FMA_LAT+1 cycles after the final beat fires.
- Bank contents are not reset. Channels are never read before k=0 initialises them.
- Reset mid-job: immediate return to IDLE, in-flight results discarded, no done pulse.

Test Plan:
- Mode 0, nch=2, klen=3, every beat act=0x3C00 (1.0) and wt=0x02, continuous valid (exercises bypass) -> ch0 and ch1 both give out_acc2=0x4600 (6.0), out_acc1=0x0000, then done pulses.
- Mode 1, nch=3, klen=2, act=0x4000 (2.0), wt=0x22 (both lanes E2M1 1.0) -> each ch gives out_acc1=out_acc2=0x4400 (4.0).
- Mode 0, nch=4, klen=2, in_valid toggling every other cycle, wt=0x01 for ch0 and 0xFF for ch1..3, act=0x3C00 -> out_acc2 = 0x4000 for ch0 and 0xC000 for ch1..3, in channel order.
- Backpressure: out_ready low for 5 cycles mid-DRAIN -> out_valid, out_ch and data held constant; no result lost or duplicated.
- start with nch=1 (< FMA_LAT), then with klen=0 -> cfg_err pulses each time; busy stays 0 and in_ready stays 0.
- reset asserted in RUN after 3 beats, then a new job (mode 0, nch=2, klen=1, act=0x3C00, wt=0x03) -> outputs are only 0x4200 for each ch, with no stale values.
